pwqe_slot_scheduler: RTL and testbench
======================================

Name: pwqe_slot_scheduler

Overview:
- Dispatch controller on station-buffer port 1, between the pWQE station buffer and ib_transport.
- Watches the slot-status vector and picks one occupied, not-yet-dispatched slot in round-robin order.
- Reads that slot's pWQE from the synchronous dual-port SRAM and presents it to ib_transport on a valid/ready interface.
- Tracks dispatched slots until ib_transport frees them, so no slot is sent twice.

Parameters:
PWQE_SLOT_NUM, 4, number of pWQE slots (power of two, at least 2)
PWQE_SLOT_ADDR_WIDTH, 2, log2(PWQE_SLOT_NUM)
PWQE_BUF_ADDR_WIDTH, 2, buffer address width; must equal PWQE_SLOT_ADDR_WIDTH (one entry per slot, address = slot index)
PWQE_BUF_WIDTH, 512, pWQE width in bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_en  in  1  scheduler enable; gates new picks only
i_slot_status  in  PWQE_SLOT_NUM  slot-occupied vector from the station buffer
i_reset_req  in  1  slot-free pulse, snooped from ib_transport
i_reset_addr  in  PWQE_SLOT_ADDR_WIDTH  slot being freed
o_ren_1  out  1  buffer port-1 read enable
o_wen_1  out  1  buffer port-1 write enable; constant 0
o_addr_1  out  PWQE_BUF_ADDR_WIDTH  buffer port-1 address
o_din_1  out  PWQE_BUF_WIDTH  buffer port-1 write data; constant 0
i_dout_1  in  PWQE_BUF_WIDTH  buffer port-1 read data, valid 1 cycle after o_ren_1
o_pwqe_valid  out  1  pWQE offered to ib_transport
o_pwqe_data  out  PWQE_BUF_WIDTH  pWQE payload
o_pwqe_slot  out  PWQE_SLOT_ADDR_WIDTH  slot index of the offered pWQE
i_pwqe_ready  in  1  ib_transport accepts
o_issued  out  PWQE_SLOT_NUM  dispatched-but-not-freed mask

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; RR pointer 0; issued mask 0.
- Eligibility: elig = i_slot_status & ~issued.
- Round-robin pick: the first set bit of elig, searching from pointer ptr upward and wrapping at PWQE_SLOT_NUM-1 to 0.
- State machine (registered outputs, one pWQE in flight at a time):
  - IDLE: if i_en and elig != 0, latch sel = pick, register o_ren_1=1 and o_addr_1=sel, go to RD. Otherwise stay.
  - RD: o_ren_1 is high this cycle. Clear it at the edge; go to CAP.
  - CAP: i_dout_1 is valid. Register o_pwqe_data=i_dout_1, o_pwqe_slot=sel, o_pwqe_valid=1; go to OUT.
  - OUT: hold valid, data and slot stable until i_pwqe_ready=1. On the handshake edge: set issued[sel], set ptr=(sel+1) mod PWQE_SLOT_NUM, clear valid, go to IDLE.
- Latency:
  - Status bit seen in IDLE at cycle 0 -> o_ren_1 high at cycle 1 -> o_pwqe_valid high at cycle 3.
  - Minimum spacing between successive dispatches is 4 cycles.
- Valid/ready rule: once o_pwqe_valid rises it does not drop, and data and slot do not change, until the handshake. i_en=0 never aborts a transfer in progress.
- i_en=0 affects only the IDLE pick; RD, CAP and OUT always complete.
- Issued-mask update:
  - i_reset_req with issued[i_reset_addr]=1 clears that bit on the same edge the station buffer clears the status bit. Status and issued therefore fall together, with no re-dispatch window.
  - i_reset_req on a non-issued slot: issued mask unchanged (the buffer clears its own status).
  - Clear of slot A and handshake set of slot B on the same edge: both apply.
  - A==B cannot happen: a freed slot is already issued and so is not eligible.
- Boundary conditions:
  - A slot's status may rise in the same cycle as an IDLE pick; it is considered only on the next IDLE evaluation.
  - All slots issued: elig=0, stay in IDLE.
  - ptr wraps from PWQE_SLOT_NUM-1 to 0.
- Port 1 is read-only from this block: o_wen_1=0 and o_din_1=0 always.
- Reset mid-transfer: immediate return to reset values. The in-flight pWQE is dropped; its buffer status stays set, so it is re-dispatched after reset.

Decomposition:
- Package pwqe_sched_pkg: state enum (IDLE, RD, CAP, OUT), state width, RD_LATENCY=1.
- Sub-module pwqe_rr_picker: combinational rotate, priority-encode, un-rotate over elig and ptr. Outputs pick index and any_valid; parameterized by PWQE_SLOT_NUM.
- FSM, issued mask and output registers live in pwqe_slot_scheduler.

Test Plan:
- Single slot: status=4'b0100, i_en=1, ready=1 -> o_ren_1 at cycle 1 with addr=2. Data from buffer entry 2 is offered at cycle 3 with o_pwqe_slot=2. issued=4'b0100 after the handshake; no second read of slot 2.
- Round robin: status=4'b1111, ready tied 1, ptr=0 -> slots dispatched in order 0,1,2,3 at 4-cycle spacing, then issued=4'b1111 and the FSM idles.
- Backpressure: ready=0 for 10 cycles while valid -> valid, data and slot are stable for all 10 cycles. One handshake occurs when ready=1.
- Free and reuse: after slot 1 is issued, reset_req addr=1 -> issued[1] clears. Status re-set on slot 1 -> slot 1 is dispatched again, with pointer-order priority.
- Wrap and simultaneous events: ptr=3, status=4'b1001 -> slot 3 first, then slot 0. Reset_req on slot 3 on the same edge as the slot-0 handshake -> issued=4'b0001.
- Async reset in OUT: assert rst_n=0 mid-cycle -> valid=0 immediately and issued=0. After release with status still 4'b0010 -> slot 1 is re-dispatched.

Source files
------------

// File: rtl/pwqe_sched_pkg.sv
// Shared constants for the pWQE slot scheduler on station-buffer port 1.
// State encodings are plain constants so older netlists keep the same codes.
package pwqe_sched_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RD   = 2'd1;
    localparam logic [STATE_W-1:0] ST_CAP  = 2'd2;
    localparam logic [STATE_W-1:0] ST_OUT  = 2'd3;

    // Buffer read data arrives this many cycles after the read enable.
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/pwqe_rr_picker.sv
// Round-robin picker: rotates elig so ptr sits at bit 0, takes the lowest set
// bit, then rotates the index back.
module pwqe_rr_picker #(
    parameter int PWQE_SLOT_NUM        = 4,
    parameter int PWQE_SLOT_ADDR_WIDTH = 2
) (
    input  logic [PWQE_SLOT_NUM-1:0]        elig,
    input  logic [PWQE_SLOT_ADDR_WIDTH-1:0] ptr,
    output logic [PWQE_SLOT_ADDR_WIDTH-1:0] pick,
    output logic                            any_valid
);

    logic [PWQE_SLOT_NUM-1:0]        rot;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0] offs;

    // Slot count is a power of two, so the index adds wrap on their own.
    always_comb begin
        rot = '0;
        for (int i = 0; i < PWQE_SLOT_NUM; i++) begin
            rot[i] = elig[PWQE_SLOT_ADDR_WIDTH'(i) + ptr];
        end
    end

    always_comb begin
        offs = '0;
        for (int i = PWQE_SLOT_NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = PWQE_SLOT_ADDR_WIDTH'(i);
            end
        end
    end

    assign pick      = offs + ptr;
    assign any_valid = |elig;

endmodule

// File: rtl/pwqe_slot_scheduler.sv
// Dispatches occupied, not-yet-issued pWQE slots round-robin from buffer
// port 1 to ib_transport; the issued mask blocks re-dispatch until freed.
//
// state | meaning
// IDLE  | waiting for an enabled pick; read enable/address registered on pick
// RD    | buffer read enable high for one cycle
// CAP   | buffer read data valid; captured into the output register
// OUT   | pWQE offered; held stable until ib_transport is ready
module pwqe_slot_scheduler
    import pwqe_sched_pkg::*;
#(
    parameter int PWQE_SLOT_NUM        = 4,
    parameter int PWQE_SLOT_ADDR_WIDTH = 2,
    parameter int PWQE_BUF_ADDR_WIDTH  = 2,
    parameter int PWQE_BUF_WIDTH       = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_en,
    input  logic [PWQE_SLOT_NUM-1:0]        i_slot_status,
    input  logic                            i_reset_req,
    input  logic [PWQE_SLOT_ADDR_WIDTH-1:0] i_reset_addr,
    output logic                            o_ren_1,
    output logic                            o_wen_1,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0]  o_addr_1,
    output logic [PWQE_BUF_WIDTH-1:0]       o_din_1,
    input  logic [PWQE_BUF_WIDTH-1:0]       i_dout_1,
    output logic                            o_pwqe_valid,
    output logic [PWQE_BUF_WIDTH-1:0]       o_pwqe_data,
    output logic [PWQE_SLOT_ADDR_WIDTH-1:0] o_pwqe_slot,
    input  logic                            i_pwqe_ready,
    output logic [PWQE_SLOT_NUM-1:0]        o_issued
);

    logic [STATE_W-1:0]              state;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0] sel;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0] ptr;
    logic [PWQE_SLOT_NUM-1:0]        issued;
    logic [PWQE_SLOT_NUM-1:0]        issued_nxt;
    logic [PWQE_SLOT_NUM-1:0]        elig;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0] pick;
    logic                            any_valid;
    logic                            handshake;

    assign elig      = i_slot_status & ~issued;
    assign handshake = (state == ST_OUT) && i_pwqe_ready;

    pwqe_rr_picker #(
        .PWQE_SLOT_NUM        (PWQE_SLOT_NUM),
        .PWQE_SLOT_ADDR_WIDTH (PWQE_SLOT_ADDR_WIDTH)
    ) u_picker (
        .elig      (elig),
        .ptr       (ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // A free and a handshake on the same edge never target the same slot.
    always_comb begin
        issued_nxt = issued;
        if (i_reset_req) begin
            issued_nxt[i_reset_addr] = 1'b0;
        end
        if (handshake) begin
            issued_nxt[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sel          <= '0;
            ptr          <= '0;
            issued       <= '0;
            o_ren_1      <= 1'b0;
            o_addr_1     <= '0;
            o_pwqe_valid <= 1'b0;
            o_pwqe_data  <= '0;
            o_pwqe_slot  <= '0;
        end else begin
            issued <= issued_nxt;
            case (state)
                ST_IDLE: begin
                    if (i_en && any_valid) begin
                        sel      <= pick;
                        o_ren_1  <= 1'b1;
                        o_addr_1 <= pick;
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    o_ren_1 <= 1'b0;
                    state   <= ST_CAP;
                end
                ST_CAP: begin
                    o_pwqe_data  <= i_dout_1;
                    o_pwqe_slot  <= sel;
                    o_pwqe_valid <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_pwqe_ready) begin
                        ptr          <= sel + 1'b1;
                        o_pwqe_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_issued = issued;
    assign o_wen_1  = 1'b0;
    assign o_din_1  = '0;

endmodule

// File: tb/tb_pwqe_slot_scheduler.sv
// Bench for pwqe_slot_scheduler: directed sequence plus a randomized phase,
// checked against a slot-level round-robin model and a simple SRAM stub.
module tb_pwqe_slot_scheduler;

    localparam int N = 4;
    localparam int W = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic [N-1:0]  slot_status = '0;
    logic          i_reset_req = 1'b0;
    logic [1:0]    i_reset_addr = '0;
    logic          o_ren_1;
    logic          o_wen_1;
    logic [1:0]    o_addr_1;
    logic [W-1:0]  o_din_1;
    logic [W-1:0]  i_dout_1 = '0;
    logic          o_pwqe_valid;
    logic [W-1:0]  o_pwqe_data;
    logic [1:0]    o_pwqe_slot;
    logic          i_pwqe_ready = 1'b0;
    logic [N-1:0]  o_issued;

    int            checks = 0;
    int            errors = 0;
    int            m_ptr = 0;
    logic [N-1:0]  m_issued = '0;
    logic [W-1:0]  mem [N];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ren_1) i_dout_1 <= mem[o_addr_1];
    end

    pwqe_slot_scheduler #(
        .PWQE_SLOT_NUM        (N),
        .PWQE_SLOT_ADDR_WIDTH (2),
        .PWQE_BUF_ADDR_WIDTH  (2),
        .PWQE_BUF_WIDTH       (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_slot_status (slot_status),
        .i_reset_req   (i_reset_req),
        .i_reset_addr  (i_reset_addr),
        .o_ren_1       (o_ren_1),
        .o_wen_1       (o_wen_1),
        .o_addr_1      (o_addr_1),
        .o_din_1       (o_din_1),
        .i_dout_1      (i_dout_1),
        .o_pwqe_valid  (o_pwqe_valid),
        .o_pwqe_data   (o_pwqe_data),
        .o_pwqe_slot   (o_pwqe_slot),
        .i_pwqe_ready  (i_pwqe_ready),
        .o_issued      (o_issued)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First occupied, non-issued slot at or after the model pointer, wrapping.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int s = (m_ptr + k) % N;
            if (slot_status[s] && !m_issued[s]) return s;
        end
        return -1;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < W / 32; j++)
                mem[i][j*32 +: 32] = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_ren", o_ren_1, 0);
        chk("rst_addr", o_addr_1, 0);
        chk("rst_valid", o_pwqe_valid, 0);
        chk("rst_data", o_pwqe_data, 0);
        chk("rst_slot", o_pwqe_slot, 0);
        chk("rst_issued", o_issued, 0);
        chk("rst_wen", o_wen_1, 0);
        chk("rst_din", o_din_1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_issued = '0;
    endtask

    // ib_transport frees slot a; the station buffer drops its status on the same edge.
    task automatic free_slot(input int a);
        i_reset_req = 1'b1;
        i_reset_addr = 2'(a);
        tick();
        i_reset_req = 1'b0;
        slot_status[a] = 1'b0;
        m_issued[a] = 1'b0;
        chk("issued_after_free", o_issued, m_issued);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        repeat (cycles) begin
            tick();
            chk(tag, o_ren_1, 0);
        end
    endtask

    // Expects an immediate pick; optionally frees free_a on the handshake edge.
    task automatic dispatch_one(input int delay, input logic en_mid, input int free_a);
        int exp;
        int n;
        logic [W-1:0] exp_data;
        exp = model_pick();
        chk("pick_exists", (exp >= 0), 1);
        if (exp < 0) exp = 0;
        exp_data = mem[exp];
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_ren_1 && n < 20);
        chk("ren_latency", n, 1);
        chk("ren_addr", o_addr_1, exp);
        i_en = en_mid;
        tick();
        chk("ren_pulse", o_ren_1, 0);
        chk("valid_early", o_pwqe_valid, 0);
        tick();
        chk("valid", o_pwqe_valid, 1);
        chk("slot", o_pwqe_slot, exp);
        chk("data", o_pwqe_data, exp_data);
        chk("wen", o_wen_1, 0);
        repeat (delay) begin
            tick();
            chk("hold_valid", o_pwqe_valid, 1);
            chk("hold_slot", o_pwqe_slot, exp);
            chk("hold_data", o_pwqe_data, exp_data);
        end
        i_pwqe_ready = 1'b1;
        if (free_a >= 0) begin
            i_reset_req = 1'b1;
            i_reset_addr = 2'(free_a);
        end
        tick();
        i_pwqe_ready = 1'b0;
        i_reset_req = 1'b0;
        m_issued[exp] = 1'b1;
        m_ptr = (exp + 1) % N;
        if (free_a >= 0) begin
            slot_status[free_a] = 1'b0;
            m_issued[free_a] = 1'b0;
        end
        chk("valid_drop", o_pwqe_valid, 0);
        chk("issued", o_issued, m_issued);
    endtask

    initial begin
        int n;
        int fa;
        int off;
        fill_mem();
        do_reset();

        // single slot
        slot_status = 4'b0100;
        i_en = 1'b1;
        dispatch_one(0, 1'b1, -1);
        idle_check(6, "no_second_read");

        // wrap from slot 3 to 0, free slot 3 on the slot-0 handshake
        free_slot(2);
        slot_status = 4'b1001;
        dispatch_one(0, 1'b1, -1);
        dispatch_one(0, 1'b1, 3);
        chk("wrap_issued", o_issued, 4'b0001);

        // backpressure with enable dropped mid-transfer
        slot_status[2] = 1'b1;
        dispatch_one(10, 1'b0, -1);
        free_slot(0);
        slot_status[0] = 1'b1;
        idle_check(5, "en_gated");
        free_slot(1);
        i_en = 1'b1;
        dispatch_one(0, 1'b1, -1);

        // free and reuse, pointer-order priority
        slot_status[1] = 1'b1;
        dispatch_one(0, 1'b1, -1);
        i_en = 1'b0;
        free_slot(1);
        slot_status[1] = 1'b1;
        slot_status[3] = 1'b1;
        i_en = 1'b1;
        dispatch_one(0, 1'b1, -1);
        dispatch_one(0, 1'b1, -1);
        chk("all_issued", o_issued, 4'b1111);
        idle_check(6, "all_issued_idle");

        // async reset while offering
        i_en = 1'b0;
        for (int s = 0; s < N; s++) free_slot(s);
        slot_status = 4'b0010;
        i_en = 1'b1;
        n = 0;
        while (!o_pwqe_valid && n < 10) begin
            tick();
            n++;
        end
        chk("pre_reset_valid", o_pwqe_valid, 1);
        #2;
        do_reset();
        dispatch_one(0, 1'b1, -1);

        // round robin from pointer 0 at 4-cycle spacing
        i_en = 1'b0;
        free_slot(1);
        do_reset();
        slot_status = 4'b1111;
        i_en = 1'b1;
        for (int k = 0; k < N; k++) dispatch_one(0, 1'b1, -1);
        chk("rr_issued", o_issued, 4'b1111);
        idle_check(4, "rr_idle");

        // randomized phase
        for (int it = 0; it < 40; it++) begin
            i_en = 1'b0;
            fill_mem();
            for (int s = 0; s < N; s++)
                if (m_issued[s] && $urandom_range(0, 2) == 0) free_slot(s);
            if ($urandom_range(0, 5) == 0) free_slot(int'($urandom_range(0, N - 1)));
            for (int s = 0; s < N; s++)
                if (!slot_status[s] && $urandom_range(0, 1) == 1) slot_status[s] = 1'b1;
            i_en = 1'b1;
            if (model_pick() < 0) begin
                idle_check(2, "rand_idle");
                continue;
            end
            fa = -1;
            if ($urandom_range(0, 1) == 1) begin
                off = int'($urandom_range(0, N - 1));
                for (int k = 0; k < N; k++)
                    if (fa < 0 && m_issued[(off + k) % N]) fa = (off + k) % N;
            end
            dispatch_one(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), fa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
